// File: rtl/count_compare_pwm_pkg.sv
// Shared constants and state encoding for the count/compare PWM block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_compare_pwm_pkg;

  // Default counter/duty width.
  localparam int CCP_WIDTH = 8;

  // The dead-time counter is 4 bits wide, so longer dead times are clamped.
  localparam int DEAD_CYCLES_MAX = 15;

  // Control FSM encoding.
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/pwm_deadtime_gen.sv
// Turns a compare result into complementary outputs with a dead gap between them.
// Latency: falling edges 1 clk after the compare changes; rising edges DEAD_CYCLES clk after the opposite fall.
// Backpressure: none; both outputs are forced low while inactive.
module pwm_deadtime_gen
  import count_compare_pwm_pkg::*;
#(
  parameter int DEAD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic cmp,
  output logic pwm_p,
  output logic pwm_n
);

  localparam int DEAD_CLAMP = (DEAD_CYCLES > DEAD_CYCLES_MAX) ? DEAD_CYCLES_MAX : DEAD_CYCLES;
  localparam logic [3:0] DEAD_LEN = 4'(DEAD_CLAMP);

  // Cycles both outputs have been low since the last fall (or since becoming active).
  logic [3:0] dead_cnt;
  logic       rise_ok;

  // A rise is allowed once the gap has lasted DEAD_LEN edges including this one.
  always_comb begin
    rise_ok = (DEAD_LEN == 4'd0) || (dead_cnt >= DEAD_LEN - 4'd1);
  end

  // Drop the opposite output first, then count out the dead gap before rising.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_p    <= 1'b0;
      pwm_n    <= 1'b0;
      dead_cnt <= 4'd0;
    end else if (!active) begin
      pwm_p    <= 1'b0;
      pwm_n    <= 1'b0;
      dead_cnt <= 4'd0;
    end else if (cmp) begin
      if (pwm_n) begin
        pwm_n    <= 1'b0;
        dead_cnt <= 4'd0;
        if (DEAD_LEN == 4'd0) pwm_p <= 1'b1;
      end else if (!pwm_p) begin
        if (rise_ok) pwm_p <= 1'b1;
        else         dead_cnt <= dead_cnt + 4'd1;
      end
    end else begin
      if (pwm_p) begin
        pwm_p    <= 1'b0;
        dead_cnt <= 4'd0;
        if (DEAD_LEN == 4'd0) pwm_n <= 1'b1;
      end else if (!pwm_n) begin
        if (rise_ok) pwm_n <= 1'b1;
        else         dead_cnt <= dead_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/count_compare_pwm.sv
// Compares an upstream counter against a double-buffered duty; PWM out plus period/match ticks.
// Latency: count -> pwm_out/match_tick 2 clk, boundary -> period_tick 2 clk after the wrapped count arrives.
// Backpressure: cfg_ready drops while a duty is pending and rises the cycle after it is swapped in.
// Optional: define PWM_DEADTIME_EN to add the complementary pwm_n output with dead time.
module count_compare_pwm
  import count_compare_pwm_pkg::*;
#(
  parameter int WIDTH = CCP_WIDTH
`ifdef PWM_DEADTIME_EN
  , parameter int DEAD_CYCLES = 2
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             count_valid,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
`ifdef PWM_DEADTIME_EN
  output logic             pwm_n,
`endif
  output logic             period_tick,
  output logic             match_tick,
  output logic             running
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_prev;
  logic             vld_q;
  logic             vld_prev;

  state_t           state;
  state_t           state_next;
  logic             pending;
  logic [WIDTH-1:0] pending_duty;
  logic [WIDTH-1:0] active_duty;
  logic [WIDTH-1:0] duty_next;

  logic             boundary;
  logic             cfg_xfer;
  logic             swap;
  logic             run_next;
  logic             cmp_next;

  // Two-deep sample history of the counter and its valid flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      count_prev <= '0;
      vld_q      <= 1'b0;
      vld_prev   <= 1'b0;
    end else begin
      count_q    <= count;
      count_prev <= count_q;
      vld_q      <= count_valid;
      vld_prev   <= vld_q;
    end
  end

  // Boundary detect, next-state logic and the duty swap decision.
  always_comb begin
    // A drop between two consecutive valid samples is a wrap or a downward reload.
    boundary   = vld_q & vld_prev & (count_q < count_prev);
    cfg_xfer   = cfg_valid & ~pending;
    state_next = state;
    swap       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en & boundary & pending) begin
          swap       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en)                     state_next = ST_IDLE;
        else if (!vld_q)             state_next = ST_HOLD;
        else if (boundary & pending) swap       = 1'b1;
      end
      ST_HOLD: begin
        if (!en)        state_next = ST_IDLE;
        else if (vld_q) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
    // Compare against the duty that is in force after this cycle's swap.
    duty_next = swap ? pending_duty : active_duty;
    run_next  = (state_next == ST_RUN);
    cmp_next  = run_next & (count_q < duty_next);
  end

  // FSM state plus the double-buffered duty registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      pending      <= 1'b0;
      pending_duty <= '0;
      active_duty  <= '0;
    end else begin
      state <= state_next;
      if (swap) begin
        active_duty <= pending_duty;
        pending     <= 1'b0;
      end else if (cfg_xfer) begin
        pending_duty <= cfg_duty;
        pending      <= 1'b1;
      end
    end
  end

  // Registered event ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_tick <= 1'b0;
      match_tick  <= 1'b0;
    end else begin
      period_tick <= boundary;
      match_tick  <= run_next & vld_q & (count_q == duty_next);
    end
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadtime_gen #(
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_deadtime (
    .clk    (clk),
    .reset  (reset),
    .active (run_next),
    .cmp    (cmp_next),
    .pwm_p  (pwm_out),
    .pwm_n  (pwm_n)
  );
`else
  // Plain registered compare output, forced low outside RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_out <= 1'b0;
    else       pwm_out <= cmp_next;
  end
`endif

  assign cfg_ready = ~pending;
  assign running   = (state == ST_RUN);

endmodule

// File: tb/tb_count_compare_pwm.sv
module tb_count_compare_pwm;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] count;
  logic       count_valid;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_duty;
  logic       cfg_ready;
  logic       pwm_out;
  logic       period_tick;
  logic       match_tick;
  logic       running;
`ifdef PWM_DEADTIME_EN
  logic       pwm_n;
  localparam logic [4:0] CMP_MASK = 5'b01111;
`else
  localparam logic [4:0] CMP_MASK = 5'b11111;
`endif

  always #5 clk = ~clk;

`ifdef PWM_DEADTIME_EN
  count_compare_pwm #(.WIDTH(8), .DEAD_CYCLES(3)) dut (
`else
  count_compare_pwm #(.WIDTH(8)) dut (
`endif
    .clk         (clk),
    .reset       (reset),
    .count       (count),
    .count_valid (count_valid),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_duty    (cfg_duty),
    .pwm_out     (pwm_out),
`ifdef PWM_DEADTIME_EN
    .pwm_n       (pwm_n),
`endif
    .period_tick (period_tick),
    .match_tick  (match_tick),
    .running     (running)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cur      = 0;

  // Reference model: samples seen by the block, operating mode, duty buffers, expected outputs.
  int m_mode;            // 0 idle, 1 run, 2 hold
  bit m_pend;
  int m_pduty, m_aduty;
  int s_cnt[2];          // [0] newest sample, [1] the one before
  bit s_vld[2];
  bit e_pwm, e_ptick, e_match, e_run;

  function automatic void model_reset();
    m_mode = 0; m_pend = 0; m_pduty = 0; m_aduty = 0;
    s_cnt[0] = 0; s_cnt[1] = 0; s_vld[0] = 0; s_vld[1] = 0;
    e_pwm = 0; e_ptick = 0; e_match = 0; e_run = 0;
  endfunction

  // One clock edge of the reference: new period if the count went down between two valid samples;
  // a pending duty goes live on such a period start whenever the block runs.
  function automatic void model_edge();
    bit new_period;
    bit offer_taken;
    if (reset) begin
      model_reset();
      return;
    end
    new_period  = s_vld[0] && s_vld[1] && (s_cnt[0] < s_cnt[1]);
    offer_taken = cfg_valid && !m_pend;
    if (!en)              m_mode = 0;
    else if (m_mode == 0) m_mode = (new_period && m_pend) ? 1 : 0;
    else                  m_mode = s_vld[0] ? 1 : 2;
    if (m_mode == 1 && new_period && m_pend) begin
      m_aduty = m_pduty;
      m_pend  = 0;
    end
    if (offer_taken) begin
      m_pduty = int'(cfg_duty);
      m_pend  = 1;
    end
    e_ptick = new_period;
    e_run   = (m_mode == 1);
    e_pwm   = e_run && (s_cnt[0] < m_aduty);
    e_match = e_run && s_vld[0] && (s_cnt[0] == m_aduty);
    s_cnt[1] = s_cnt[0]; s_vld[1] = s_vld[0];
    s_cnt[0] = int'(count); s_vld[0] = count_valid;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic apply(input int c, input bit v);
    count = 8'(c);
    count_valid = v;
    tick();
  endtask

  task automatic step_cnt();
    cur = (cur + 1) % 256;
    apply(cur, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1; en = 0; cfg_valid = 0; cfg_duty = 0; count = 0; count_valid = 0;
    model_reset();
    tick(); tick();
    n_checks++; if (pwm_out !== 1'b0)     begin n_fail++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
    n_checks++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL reset_ptick got %b want 0", period_tick); end
    n_checks++; if (match_tick !== 1'b0)  begin n_fail++; $display("FAIL reset_match got %b want 0", match_tick); end
    n_checks++; if (running !== 1'b0)     begin n_fail++; $display("FAIL reset_running got %b want 0", running); end
    n_checks++; if (cfg_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    reset = 0;
    cur = 255;
  endtask

  task automatic test_idle_ramp();
    logic [4:0] obs, exp;
    int ticks = 0;
    en = 1;
    for (int i = 0; i < 280; i++) begin
      step_cnt();
      if (period_tick === 1'b1) ticks++;
      obs = {pwm_out, period_tick, match_tick, running, cfg_ready};
      exp = {e_pwm, e_ptick, e_match, e_run, !m_pend};
      n_checks++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL idle_ramp cyc %0d got %b want %b", cyc, obs, exp);
      end
    end
    n_checks++;
    if (ticks !== 1) begin n_fail++; $display("FAIL idle_ramp_ticks got %0d want 1", ticks); end
  endtask

  task automatic test_duty_offer(input int at_cnt, input int duty, input string name);
    logic [4:0] obs, exp;
    bit offered = 0;
    for (int i = 0; i < 600; i++) begin
      cfg_valid = (!offered && cur == at_cnt - 1);
      cfg_duty  = 8'(duty);
      if (cfg_valid) offered = 1;
      step_cnt();
      cfg_valid = 0;
      obs = {pwm_out, period_tick, match_tick, running, cfg_ready};
      exp = {e_pwm, e_ptick, e_match, e_run, !m_pend};
      n_checks++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL %s cyc %0d got %b want %b", name, cyc, obs, exp);
      end
    end
  endtask

  task automatic test_reload_hold();
    logic [4:0] obs, exp;
    bit offered = 0;
    int i = 0;
    while (i < 700) begin
      i++;
      if (i < 600 && offered && cur == 180) begin
        cur = 9;             // upstream reload 180 -> 10
      end else if (i >= 600 && i < 605) begin
        count = 8'($urandom); count_valid = 0;
        tick();
        obs = {pwm_out, period_tick, match_tick, running, cfg_ready};
        exp = {e_pwm, e_ptick, e_match, e_run, !m_pend};
        n_checks++;
        if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
          n_fail++; $display("FAIL hold cyc %0d got %b want %b", cyc, obs, exp);
        end
        continue;
      end
      cfg_valid = (!offered && cur == 49);
      cfg_duty  = 8'd64;
      if (cfg_valid) offered = 1;
      step_cnt();
      cfg_valid = 0;
      obs = {pwm_out, period_tick, match_tick, running, cfg_ready};
      exp = {e_pwm, e_ptick, e_match, e_run, !m_pend};
      n_checks++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL reload cyc %0d got %b want %b", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs, exp;
    int phase = 0;
    for (int i = 0; i < 600 && phase < 3; i++) begin
      cfg_valid = (phase == 1 && cur == 19);
      cfg_duty  = 8'd128;
      step_cnt();
      cfg_valid = 0;
      if (phase == 0 && cur == 255) phase = 1;
      else if (phase == 1 && cur == 20) phase = 2;
      else if (phase == 2 && cur == 30) phase = 3;
    end
    obs = {pwm_out, period_tick, match_tick, running, cfg_ready};
    exp = {e_pwm, e_ptick, e_match, e_run, !m_pend};
    n_checks++;
    if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
      n_fail++; $display("FAIL pre_reset got %b want %b", obs, exp);
    end
    #2 reset = 1;
    model_reset();
    #1;
    n_checks++; if (pwm_out !== 1'b0)     begin n_fail++; $display("FAIL async_reset_pwm got %b want 0", pwm_out); end
    n_checks++; if (running !== 1'b0)     begin n_fail++; $display("FAIL async_reset_running got %b want 0", running); end
    n_checks++; if (match_tick !== 1'b0)  begin n_fail++; $display("FAIL async_reset_match got %b want 0", match_tick); end
    n_checks++; if (period_tick !== 1'b0) begin n_fail++; $display("FAIL async_reset_ptick got %b want 0", period_tick); end
    n_checks++; if (cfg_ready !== 1'b1)   begin n_fail++; $display("FAIL async_reset_ready got %b want 1", cfg_ready); end
    tick();
    reset = 0;
    for (int i = 0; i < 300; i++) begin
      step_cnt();
      obs = {pwm_out, period_tick, match_tick, running, cfg_ready};
      exp = {e_pwm, e_ptick, e_match, e_run, !m_pend};
      n_checks++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL post_reset cyc %0d got %b want %b", cyc, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] obs, exp;
    int gap = 0;
    int r;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (gap == 0 && r < 2) gap = int'($urandom_range(1, 6));
      en = (r != 99);
      cfg_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       cfg_duty = 8'd0;
        1:       cfg_duty = 8'd255;
        2:       cfg_duty = 8'd1;
        default: cfg_duty = 8'($urandom);
      endcase
      if (gap > 0) begin
        gap--;
        apply(int'($urandom_range(0, 255)), 1'b0);
      end else begin
        if (r >= 2 && r < 6) cur = int'($urandom_range(0, 255));
        step_cnt();
      end
      cfg_valid = 0;
      obs = {pwm_out, period_tick, match_tick, running, cfg_ready};
      exp = {e_pwm, e_ptick, e_match, e_run, !m_pend};
      n_checks++;
      if ((obs & CMP_MASK) !== (exp & CMP_MASK)) begin
        n_fail++; $display("FAIL random cyc %0d got %b want %b", cyc, obs, exp);
      end
    end
    en = 1;
  endtask

`ifdef PWM_DEADTIME_EN
  task automatic test_deadtime();
    int fall_p = -1, fall_n = -1;
    bit prev_p = 0, prev_n = 0;
    bit offered = 0;
    reset = 1; model_reset(); tick(); reset = 0;
    cur = 200;
    for (int i = 0; i < 700; i++) begin
      cfg_valid = (!offered && cur == 219);
      cfg_duty  = 8'd64;
      if (cfg_valid) offered = 1;
      step_cnt();
      cfg_valid = 0;
      n_checks++;
      if (pwm_out && pwm_n) begin n_fail++; $display("FAIL dt_overlap cyc %0d got p=1 n=1 want not both", cyc); end
      n_checks++;
      if (!e_run && (pwm_out || pwm_n)) begin
        n_fail++; $display("FAIL dt_inactive cyc %0d got p=%b n=%b want 0 0", cyc, pwm_out, pwm_n);
      end
      if (pwm_out && !prev_p && fall_n >= 0) begin
        n_checks++;
        if (cyc - fall_n != 3) begin n_fail++; $display("FAIL dt_p_rise got gap %0d want 3", cyc - fall_n); end
      end
      if (pwm_n && !prev_n && fall_p >= 0) begin
        n_checks++;
        if (cyc - fall_p != 3) begin n_fail++; $display("FAIL dt_n_rise got gap %0d want 3", cyc - fall_p); end
      end
      if (!pwm_out && prev_p) fall_p = cyc;
      if (!pwm_n && prev_n)   fall_n = cyc;
      prev_p = pwm_out; prev_n = pwm_n;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_ramp();
    test_duty_offer(100, 64, "duty_64");
    test_duty_offer(100, 200, "duty_200");
    test_reload_hold();
    test_reset_mid();
    test_random();
`ifdef PWM_DEADTIME_EN
    test_deadtime();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_compare_pwm.md
Name: count_compare_pwm

Overview:
- Downstream consumer of the 8-bit programmable counter output.
- Samples the counter value and detects period boundaries, either natural wrap 255->0 or a downward reload.
- Compares the counter against a double-buffered duty register and drives a glitch-free PWM output plus event ticks.
- Duty updates arrive over a valid/ready config handshake and take effect only at a period boundary.

Parameters:
- WIDTH, 8, counter/duty width in bits; all arithmetic is unsigned WIDTH bits.
- DEAD_CYCLES, 2, dead-time length in clk cycles; used only with PWM_DEADTIME_EN; legal range 0..15.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state.
- count  input  WIDTH  counter value from the upstream counter; don't-care when count_valid=0 (may be Z).
- count_valid  input  1  high when count is driven (tie to the counter's output enable).
- en  input  1  block enable; low forces IDLE.
- cfg_valid  input  1  new duty offered.
- cfg_ready  output  1  block can accept a duty; equals !pending.
- cfg_duty  input  WIDTH  requested duty (high time in counts).
- pwm_out  output  1  registered PWM output.
- period_tick  output  1  one-cycle pulse per detected period boundary.
- match_tick  output  1  one-cycle pulse when the sampled count equals active duty in RUN.
- running  output  1  high in RUN state.

Behaviour:
- Reset: pwm_out=0, period_tick=0, match_tick=0, running=0, cfg_ready=1. Internally: state=IDLE, pending=0, active_duty=0, pending_duty=0, all samples 0.
- Input stage, every cycle:
  - count_q<=count, count_prev<=count_q.
  - vld_q<=count_valid, vld_prev<=vld_q.
- Boundary: boundary = vld_q & vld_prev & (count_q < count_prev). No boundary is detected on the first valid sample after an invalid gap.
- Config handshake:
  - Transfer when cfg_valid & cfg_ready; pending_duty<=cfg_duty, pending<=1.
  - cfg_ready=!pending, combinational from the register.
  - A transfer in the same cycle as a boundary is not swapped on that boundary; it waits for the next one.
- States:
  - IDLE: pwm_out=0. If en & boundary & pending: active_duty<=pending_duty, pending<=0, go to RUN.
  - RUN: on boundary with pending, swap active_duty the same way and stay in RUN. If vld_q=0, go to HOLD. If en=0, go to IDLE.
  - HOLD: pwm_out=0, match_tick=0. When vld_q=1, go to RUN. If en=0, go to IDLE.
  - pending and pending_duty are retained across en=0 and across HOLD.
- Compare, RUN only, registered:
  - pwm_out<=(count_q < active_duty), evaluated against the active_duty in effect after any swap this cycle.
  - Latency: count input to pwm_out is 2 clk.
- Duty limits: duty=0 gives pwm_out always 0. duty=255 gives pwm_out high except at count 255. There is no 100% duty at WIDTH=8; this is intended.
- period_tick<=boundary in all states. match_tick<=RUN & vld_q & (count_q==active_duty).
- Reset asserted mid-period: all outputs drop to 0 asynchronously and any pending duty is discarded.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- With the macro defined:
  - Adds output pwm_n (1 bit), the complement of the compare result.
  - Each rising edge of either output is delayed by DEAD_CYCLES clk after the other output falls, so both are never high together.
  - A 4-bit dead-time counter is reset to 0. pwm_n=0 in IDLE and HOLD and at reset.
- Without the macro: no pwm_n port, no dead-time logic; pwm_out timing as above.

Decomposition:
- Shared package holds the state enum (IDLE, RUN, HOLD), WIDTH default constant, and DEAD_CYCLES maximum (15).
- One sub-module is natural: pwm_deadtime_gen, containing the compare-to-complementary-output dead-time logic, instantiated only under PWM_DEADTIME_EN.
- Boundary detection and FSM stay in the top module.

Test Plan:
- Reset, then count ramps 0..255 with count_valid=1 and no cfg -> pwm_out=0 throughout, period_tick pulses 2 clk after each 255->0, running=0.
- cfg_duty=64 accepted mid-period -> cfg_ready low until next boundary. Then RUN: pwm_out high for counts 0..63, low for 64..255; match_tick 2 clk after count=64.
- In RUN at duty 64, offer duty=200 at count 100 -> output unchanged until wrap; next period high for 0..199; cfg_ready returns to 1 the cycle after the boundary.
- Upstream reloads count 180->10 at duty 64 -> period_tick fires and a pending swap occurs. count_valid=0 for 5 cycles -> HOLD, pwm_out=0; re-assert -> RUN without a false period_tick.
- Assert reset at count 30 during RUN with pending=1 -> all outputs 0 immediately; after release, state IDLE, cfg_ready=1, old pending duty lost.
- PWM_DEADTIME_EN, DEAD_CYCLES=3, duty=64 -> pwm_out and pwm_n never both 1; each rising edge is 3 clk after the opposite falling edge.
